counter_updown_param: RTL and testbench
=======================================

Name: counter_updown_param

Overview:
- Parametrised up/down counter; successor to the fixed 4-bit up/down counter.
- Adds generic width, runtime modulus (limit), enable, synchronous clear and parallel load.
- Selectable wrap or saturate mode; registered boundary-event pulse.
- Used as a general event/timer counter in datapath and control blocks.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- RESET_VAL, 0, value of count after rst_n assertion; must be <= 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; one step per clock while high.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value for load.
- up_down  input  1  direction: 1 = up, 0 = down.
- sat_mode  input  1  boundary mode: 0 = wrap, 1 = saturate.
- limit  input  WIDTH  upper bound (inclusive) of the count range [0, limit].
- count  output  WIDTH  current count (registered).
- evt  output  1  registered one-cycle boundary-event pulse.
- ovf  output  1  sticky boundary flag (see Optional Feature).

Behaviour:
- Reset: rst_n low asynchronously forces count=RESET_VAL, evt=0, ovf=0; rst_n low mid-count aborts immediately. First update occurs on the first rising edge after rst_n deasserts.
- Per-edge priority: clr > load > en-step > hold.
  - clr: count<=0, evt<=0.
  - load: count<=load_val (loaded as-is even if > limit), evt<=0.
  - en=0: count holds, evt<=0.
- Up step (en=1, up_down=1):
  - count < limit: count+1, evt<=0.
  - count >= limit, wrap mode: count<=0, evt<=1.
  - count >= limit, saturate mode: count<=limit, evt<=1. Out-of-range values clamp to limit.
- Down step (en=1, up_down=0):
  - count > 0: count-1, evt<=0, even if count > limit (counts down into range).
  - count == 0, wrap mode: count<=limit, evt<=1.
  - count == 0, saturate mode: count holds 0, evt<=1.
- Saturate mode: evt re-asserts on every enabled step attempted at the boundary.
- limit=0: up and down steps both yield 0 with evt=1 every enabled cycle.
- limit=2^WIDTH-1: full natural modulus; no overflow beyond WIDTH bits.
- limit, sat_mode and up_down are sampled each edge; changes take effect on the same edge they are seen.
- All arithmetic is unsigned WIDTH-bit. The comparison count >= limit is unsigned.
- Latency: count and evt reflect the operation one clock after the sampling edge (registered outputs only, no combinational input-to-output path).

Optional Feature:
- Macro: COUNTER_UPDOWN_STICKY_OVF_EN.
- Defined: ovf sets to 1 on any edge where evt is set to 1. Stays set until clr (sync, same edge count clears) or rst_n low. load does not clear ovf. If clr and a boundary step occur together, clr wins and ovf<=0.
- Undefined: ovf is tied to constant 0; no sticky register is synthesised.

Test Plan:
- Reset: RESET_VAL=5, WIDTH=4, rst_n pulsed low between edges -> count=5, evt=0, ovf=0 immediately, without waiting for clk.
- Wrap up: WIDTH=4, limit=9, sat_mode=0, up, en=1 from 0 -> count 1..9, then 0 with evt=1 for exactly the cycle after the 9->0 edge.
- Wrap down / saturate: limit=9, down from 0 -> 9, evt=1. With sat_mode=1, down at 0 for 3 cycles -> count stays 0, evt=1 each cycle.
- Priority: load_val=12, limit=9, load=1 and clr=1 same edge -> count=0. Next edge load only -> count=12. Next up step -> 0 with evt=1 (wrap) or 9 (saturate).
- Enable/limit edges: en=0 for 4 cycles -> count holds, evt=0. limit=0 with en=1 -> count=0, evt=1 every cycle. limit=15 up from 15 -> 0, evt=1.
- Sticky (macro defined): trigger one wrap -> ovf=1. Persists through 10 normal steps and a load. clr -> ovf=0. With macro undefined, ovf=0 throughout the same sequence.

Source files
------------

// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with runtime limit, wrap/saturate boundary modes and a registered event pulse.
// Define COUNTER_UPDOWN_STICKY_OVF_EN to get a sticky ovf flag; otherwise ovf is tied to 0.
module counter_updown_param #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             evt,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] step_count;
  logic             at_bound;

  // Boundary test uses >= so out-of-range loaded values also hit the limit on an up step.
  always_comb begin
    step_count = count;
    at_bound   = 1'b0;
    if (up_down) begin
      if (count >= limit) begin
        at_bound   = 1'b1;
        step_count = sat_mode ? limit : '0;
      end else begin
        step_count = count + 1'b1;
      end
    end else begin
      if (count == '0) begin
        at_bound   = 1'b1;
        step_count = sat_mode ? '0 : limit;
      end else begin
        step_count = count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_COUNT;
      evt   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      evt   <= 1'b0;
    end else if (load) begin
      count <= load_val;
      evt   <= 1'b0;
    end else if (en) begin
      count <= step_count;
      evt   <= at_bound;
    end else begin
      evt   <= 1'b0;
    end
  end

`ifdef COUNTER_UPDOWN_STICKY_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (clr) begin
      ovf <= 1'b0;
    end else if (!load && en && at_bound) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_counter_updown_param.sv
// Randomised and directed bench for counter_updown_param (WIDTH=4, RESET_VAL=5) against an integer reference model.
module tb_counter_updown_param;

  localparam int unsigned W  = 4;
  localparam int unsigned RV = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0, clr = 1'b0, load = 1'b0, up_down = 1'b1, sat_mode = 1'b0;
  logic [W-1:0] load_val = '0, limit = 4'd9;
  logic [W-1:0] count;
  logic         evt, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  int  m_count;
  bit  m_evt, m_ovf;

  counter_updown_param #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_down(up_down), .sat_mode(sat_mode), .limit(limit),
    .count(count), .evt(evt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge as the specification describes it, in plain integer arithmetic.
  task automatic model_edge();
    int lim;
    lim = int'(limit);
    if (clr) begin
      m_count = 0; m_evt = 0; m_ovf = 0;
    end else if (load) begin
      m_count = int'(load_val); m_evt = 0;
    end else if (en) begin
      if (up_down) begin
        if (m_count < lim) begin m_count = m_count + 1; m_evt = 0; end
        else begin m_count = sat_mode ? lim : 0; m_evt = 1; end
      end else begin
        if (m_count > 0) begin m_count = m_count - 1; m_evt = 0; end
        else begin m_count = sat_mode ? 0 : lim; m_evt = 1; end
      end
    end else begin
      m_evt = 0;
    end
`ifdef COUNTER_UPDOWN_STICKY_OVF_EN
    if (m_evt) m_ovf = 1;
`else
    m_ovf = 0;
`endif
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, int'(count), m_count);
    check({tag, ".evt"},   int'(evt),   int'(m_evt));
    check({tag, ".ovf"},   int'(ovf),   int'(m_ovf));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic cyc(input string tag, input bit e, input bit c, input bit l, input int lv,
                     input bit ud, input bit s, input int lm);
    en = e; clr = c; load = l; load_val = W'(lv); up_down = ud; sat_mode = s; limit = W'(lm);
    step(tag);
  endtask

  task automatic async_reset(input string tag);
    #3 rst_n = 1'b0;
    #1;
    m_count = RV; m_evt = 0; m_ovf = 0;
    check_all(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    m_count = 0; m_evt = 0; m_ovf = 0;
    async_reset("reset");
    cyc("clr0", 1, 1, 0, 0, 1, 0, 9);

    for (int i = 0; i < 10; i++) cyc("wrap_up", 1, 0, 0, 0, 1, 0, 9);
    cyc("wrap_up_after", 0, 0, 0, 0, 1, 0, 9);
    cyc("wrap_down", 1, 0, 0, 0, 0, 0, 9);
    cyc("clr1", 0, 1, 0, 0, 0, 1, 9);
    for (int i = 0; i < 3; i++) cyc("sat_down", 1, 0, 0, 0, 0, 1, 9);

    cyc("prio_clr_load", 1, 1, 1, 12, 1, 0, 9);
    cyc("prio_load", 1, 0, 1, 12, 1, 0, 9);
    cyc("oor_wrap_up", 1, 0, 0, 0, 1, 0, 9);
    cyc("prio_load2", 1, 0, 1, 12, 1, 1, 9);
    cyc("oor_sat_up", 1, 0, 0, 0, 1, 1, 9);
    cyc("oor_load3", 0, 0, 1, 13, 1, 0, 9);
    cyc("oor_down", 1, 0, 0, 0, 0, 0, 9);

    for (int i = 0; i < 4; i++) cyc("hold", 0, 0, 0, 0, 1, 0, 9);
    for (int i = 0; i < 3; i++) cyc("lim0_up", 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cyc("lim0_down", 1, 0, 0, 0, 0, 1, 0);
    cyc("ld15", 0, 0, 1, 15, 1, 0, 15);
    cyc("lim15_up", 1, 0, 0, 0, 1, 0, 15);

    // sticky sequence: one wrap, ten normal steps, a load, then clear
    cyc("st_clr", 0, 1, 0, 0, 1, 0, 9);
    cyc("st_ld9", 0, 0, 1, 9, 1, 0, 9);
    cyc("st_wrap", 1, 0, 0, 0, 1, 0, 9);
    for (int i = 0; i < 8; i++) cyc("st_up", 1, 0, 0, 0, 1, 0, 9);
    for (int i = 0; i < 2; i++) cyc("st_down", 1, 0, 0, 0, 0, 0, 9);
    cyc("st_load", 0, 0, 1, 3, 1, 0, 9);
    cyc("st_clr2", 0, 1, 0, 0, 1, 0, 9);

    cyc("pre_mid_rst", 1, 0, 0, 0, 1, 0, 9);
    cyc("pre_mid_rst", 1, 0, 0, 0, 1, 0, 9);
    async_reset("mid_reset");
    cyc("post_rst", 1, 0, 0, 0, 1, 0, 9);

    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      en       = (r < 80);
      clr      = ($urandom_range(0, 99) < 4);
      load     = ($urandom_range(0, 99) < 8);
      load_val = W'($urandom);
      up_down  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) sat_mode = ~sat_mode;
      if ($urandom_range(0, 19) == 0) limit = W'($urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
